// File: rtl/decimal_key_entry.sv
// Decimal operand entry: turns debounced digit/clear/backspace/enter presses into a
// binary operand and offers it to the ALU over a valid/ready handshake.
module decimal_key_entry #(
  parameter  int NUM_DIGITS = 4,
  parameter  int WIDTH      = 14,
  localparam int CW         = $clog2(NUM_DIGITS + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [9:0]       pb,
  input  logic             pb_clr,
  input  logic             pb_bksp,
  input  logic             pb_enter,
  output logic [WIDTH-1:0] value,
  output logic [CW-1:0]    digit_count,
  output logic             full,
  output logic [WIDTH-1:0] result,
  output logic             result_valid,
  input  logic             result_ready,
  output logic             err
);

  // Handshake: result is offered while result_valid is high and held stable;
  // the transfer happens on any rising edge where result_valid && result_ready.
  typedef enum logic {ST_ENTRY, ST_WAIT} state_t;

  state_t           r_state, w_state_nxt;
  logic [12:0]      r_prev;
  logic [12:0]      w_cur, w_press;
  logic [WIDTH-1:0] r_value, w_value_nxt;
  logic [WIDTH-1:0] r_result, w_result_nxt;
  logic [WIDTH-1:0] w_value_div;
  logic [CW-1:0]    r_count, w_count_nxt;
  logic             r_full;
  logic             r_valid, w_valid_nxt;
  logic             r_err, w_err_nxt;
  logic [3:0]       w_digit;
  logic             w_digit_any, w_digit_one;
  logic [WIDTH+3:0] w_ext, w_mac;

  assign w_cur   = {pb_enter, pb_bksp, pb_clr, pb};
  assign w_press = w_cur & ~r_prev;

  always_comb begin
    w_digit = '0;
    for (int i = 0; i < 10; i++) begin
      if (w_press[i]) w_digit = 4'(i);
    end
  end

  assign w_digit_any = |w_press[9:0];
  assign w_digit_one = $onehot(w_press[9:0]);

  // Shift-and-add x10 at WIDTH+4 bits; the WIDTH constraint keeps the top bits zero.
  assign w_ext       = {4'd0, r_value};
  assign w_mac       = (w_ext << 3) + (w_ext << 1) + {{WIDTH{1'b0}}, w_digit};
  assign w_value_div = r_value / WIDTH'(10);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_ENTRY;
    else        r_state <= w_state_nxt;
  end

  // Priority within ENTRY: clr > bksp > enter > digit; lower presses are dropped.
  always_comb begin
    w_state_nxt  = r_state;
    w_value_nxt  = r_value;
    w_count_nxt  = r_count;
    w_result_nxt = r_result;
    w_valid_nxt  = r_valid;
    w_err_nxt    = 1'b0;
    case (r_state)
      ST_ENTRY: begin
        if (w_press[10]) begin
          w_value_nxt = '0;
          w_count_nxt = '0;
        end else if (w_press[11]) begin
          if (r_count != '0) begin
            w_value_nxt = w_value_div;
            w_count_nxt = r_count - CW'(1);
          end
        end else if (w_press[12]) begin
          if (r_count != '0) begin
            w_result_nxt = r_value;
            w_value_nxt  = '0;
            w_count_nxt  = '0;
            w_valid_nxt  = 1'b1;
            w_state_nxt  = ST_WAIT;
          end else begin
            w_err_nxt = 1'b1;
          end
        end else if (w_digit_any) begin
          if (w_digit_one && (r_count < CW'(NUM_DIGITS))) begin
            w_value_nxt = WIDTH'(w_mac);
            w_count_nxt = r_count + CW'(1);
          end else begin
            w_err_nxt = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        if (r_valid && result_ready) begin
          w_valid_nxt = 1'b0;
          w_state_nxt = ST_ENTRY;
        end
      end
      default: w_state_nxt = ST_ENTRY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev   <= '0;
      r_value  <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_result <= '0;
      r_valid  <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_prev   <= w_cur;
      r_value  <= w_value_nxt;
      r_count  <= w_count_nxt;
      r_full   <= (w_count_nxt == CW'(NUM_DIGITS));
      r_result <= w_result_nxt;
      r_valid  <= w_valid_nxt;
      r_err    <= w_err_nxt;
    end
  end

  assign value        = r_value;
  assign digit_count  = r_count;
  assign full         = r_full;
  assign result       = r_result;
  assign result_valid = r_valid;
  assign err          = r_err;

endmodule
